seq_datapath_unit: RTL and testbench

Parametrised sequential datapath unit with a WIDTH-bit accumulator, an internal clock-enable prescaler and a command handshake. It executes LOAD, ADD, SUB, multi-step SHL/SHR and CLR, one step per prescaler tick, and reports completion with a one-cycle pulse. It replaces the fixed 5-bit register, adder, shifter and mux datapath. The board top level drives it from switches and keys and shows `acc` on the LEDs.

---
 rtl/seq_datapath_unit.sv | 177 +++++++++++++++++
 tb/tb_seq_datapath_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_datapath_unit.sv
// Sequential accumulator datapath: prescaled step enable, command handshake, multi-step shifts.
// Optional build macro SEQ_DATAPATH_SATURATE_EN makes ADD/SUB clamp instead of wrap.
module seq_datapath_unit #(
   parameter int WIDTH    = 5,
   parameter int DIV_BITS = 25,
   parameter int AMT_BITS = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [2:0]          cmd_op,
   input  logic [WIDTH-1:0]    cmd_data,
   input  logic [AMT_BITS-1:0] cmd_amt,
   output logic [WIDTH-1:0]    acc,
   output logic                carry,
   output logic                busy,
   output logic                done,
   output logic                tick
);

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_SHL  = 3'b100;
   localparam logic [2:0] OP_SHR  = 3'b101;
   localparam logic [2:0] OP_CLR  = 3'b111;

   localparam logic [AMT_BITS-1:0] AMT_ONE = 1;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [WIDTH-1:0]    data_q, data_d;
   logic [AMT_BITS-1:0] rem_q, rem_d;
   logic [WIDTH-1:0]    acc_q, acc_d;
   logic                carry_q, carry_d;
   logic                done_q, done_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic                busy_q, busy_d;

   logic [WIDTH:0]      sum, diff;
   logic                is_shift;

   // Prescaler: the enable is the all-ones state of a wrapping counter.
   generate
      if (DIV_BITS == 0) begin : g_nodiv
         assign tick = 1'b1;
      end else begin : g_div
         localparam logic [DIV_BITS-1:0] PRE_ONE = 1;
         logic [DIV_BITS-1:0] presc_q, presc_d;

         always_comb presc_d = presc_q + PRE_ONE;

         always_ff @(posedge clk) begin
            if (reset) presc_q <= '0;
            else       presc_q <= presc_d;
         end

         assign tick = &presc_q;
      end
   endgenerate

   always_comb begin
      sum      = {1'b0, acc_q} + {1'b0, data_q};
      diff     = {1'b0, acc_q} - {1'b0, data_q};
      is_shift = (op_q == OP_SHL) || (op_q == OP_SHR);
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      data_d  = data_q;
      rem_d   = rem_q;
      acc_d   = acc_q;
      carry_d = carry_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d    = cmd_op;
               data_d  = cmd_data;
               rem_d   = cmd_amt;
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            if (tick) begin
               case (op_q)
                  OP_LOAD: acc_d = data_q;
                  OP_ADD: begin
                     carry_d = sum[WIDTH];
`ifdef SEQ_DATAPATH_SATURATE_EN
                     acc_d   = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
                     acc_d   = sum[WIDTH-1:0];
`endif
                  end
                  OP_SUB: begin
                     // Bit WIDTH of the zero-extended difference is the borrow.
                     carry_d = diff[WIDTH];
`ifdef SEQ_DATAPATH_SATURATE_EN
                     acc_d   = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
                     acc_d   = diff[WIDTH-1:0];
`endif
                  end
                  OP_SHL: begin
                     if (rem_q != '0) begin
                        carry_d = acc_q[WIDTH-1];
                        acc_d   = {acc_q[WIDTH-2:0], 1'b0};
                     end
                  end
                  OP_SHR: begin
                     if (rem_q != '0) begin
                        carry_d = acc_q[0];
                        acc_d   = {1'b0, acc_q[WIDTH-1:1]};
                     end
                  end
                  OP_CLR: begin
                     acc_d   = '0;
                     carry_d = 1'b0;
                  end
                  default: ;
               endcase

               if (is_shift && (rem_q > AMT_ONE)) begin
                  rem_d = rem_q - AMT_ONE;
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase

      cmd_ready_d = (state_d == S_IDLE);
      busy_d      = ~cmd_ready_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         op_q        <= OP_NOP;
         data_q      <= '0;
         rem_q       <= '0;
         acc_q       <= '0;
         carry_q     <= 1'b0;
         done_q      <= 1'b0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         data_q      <= data_d;
         rem_q       <= rem_d;
         acc_q       <= acc_d;
         carry_q     <= carry_d;
         done_q      <= done_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign acc       = acc_q;
   assign carry     = carry_q;
   assign done      = done_q;
   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_seq_datapath_unit.sv
// Directed bench for seq_datapath_unit at WIDTH=5, DIV_BITS=2, AMT_BITS=3.
module tb_seq_datapath_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [4:0] cmd_data;
   logic [2:0] cmd_amt;
   logic [4:0] acc;
   logic       carry, busy, done, tick;

   int n_chk  = 0;
   int n_fail = 0;

   seq_datapath_unit #(.WIDTH(5), .DIV_BITS(2), .AMT_BITS(3)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_amt(cmd_amt),
      .acc(acc), .carry(carry), .busy(busy), .done(done), .tick(tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive at negedge once ready; accepted on the following posedge.
   task automatic send(input logic [2:0] op, input logic [4:0] d, input logic [2:0] a);
      int n = 0;
      while (!cmd_ready && n < 40) begin @(negedge clk); n++; end
      chk("ready_timeout", 32'(cmd_ready), 32'd1);
      cmd_op = op; cmd_data = d; cmd_amt = a; cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Returns edges after acceptance until done is seen.
   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 60) begin @(negedge clk); n++; end
      chk("done_timeout", 32'(done), 32'd1);
   endtask

   task automatic run(input logic [2:0] op, input logic [4:0] d, input logic [2:0] a);
      int n;
      send(op, d, a);
      wait_done(n);
   endtask

   initial begin
      int n, cnt, first, last, bad_gap, nchg, dcnt, dcyc, dseen;
      logic [4:0] prev;
      logic [4:0] vals [3];
      logic       cars [3];
      int         cyc  [3];

      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_data = '0; cmd_amt = '0;
      repeat (3) @(negedge clk);
      chk("rst_acc",   32'(acc),       32'd0);
      chk("rst_carry", 32'(carry),     32'd0);
      chk("rst_done",  32'(done),      32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_tick",  32'(tick),      32'd0);

      // Prescaler: k edges after release the counter holds k mod 4.
      reset = 1'b0;
      cnt = 0; first = -1; last = -1; bad_gap = 0;
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         if (tick) begin
            if (first < 0) first = k;
            else if (k - last != 4) bad_gap++;
            last = k;
            cnt++;
         end
      end
      chk("tick_count", 32'(cnt),     32'd16);
      chk("tick_first", 32'(first),   32'd3);
      chk("tick_gap",   32'(bad_gap), 32'd0);

      // LOAD / ADD
      run(3'b001, 5'b10110, 3'd0);
      chk("load_acc",   32'(acc),   32'b10110);
      chk("load_carry", 32'(carry), 32'd0);
      run(3'b010, 5'b01101, 3'd0);
`ifdef SEQ_DATAPATH_SATURATE_EN
      chk("add_acc",    32'(acc),   32'b11111);
`else
      chk("add_acc",    32'(acc),   32'b00011);
`endif
      chk("add_carry",  32'(carry), 32'd1);

      // LOAD keeps carry; SUB borrows
      run(3'b001, 5'b00011, 3'd0);
      chk("load_keep_carry", 32'(carry), 32'd1);
      run(3'b011, 5'b00101, 3'd0);
`ifdef SEQ_DATAPATH_SATURATE_EN
      chk("sub_acc",    32'(acc),   32'b00000);
`else
      chk("sub_acc",    32'(acc),   32'b11110);
`endif
      chk("sub_carry",  32'(carry), 32'd1);

      // NOP and reserved leave everything alone
      run(3'b000, 5'b10101, 3'd0);
      run(3'b110, 5'b10101, 3'd0);
`ifdef SEQ_DATAPATH_SATURATE_EN
      chk("nop_acc",    32'(acc),   32'b00000);
`else
      chk("nop_acc",    32'(acc),   32'b11110);
`endif
      chk("nop_carry",  32'(carry), 32'd1);

      run(3'b111, 5'b11111, 3'd0);
      chk("clr_acc",    32'(acc),   32'd0);
      chk("clr_carry",  32'(carry), 32'd0);

      // Multi-step SHL by 3 on 10011
      run(3'b001, 5'b10011, 3'd0);
      send(3'b100, 5'b00000, 3'd3);
      chk("shl_busy",  32'(busy),      32'd1);
      chk("shl_ready", 32'(cmd_ready), 32'd0);
      prev = acc; nchg = 0; dcnt = 0; dcyc = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (acc !== prev && nchg < 3) begin
            vals[nchg] = acc; cars[nchg] = carry; cyc[nchg] = i; nchg++;
         end
         prev = acc;
         if (done) begin dcnt++; dcyc = i; end
      end
      chk("shl_nchg", 32'(nchg), 32'd3);
      if (nchg == 3) begin
         chk("shl_v0", 32'(vals[0]), 32'b00110);
         chk("shl_c0", 32'(cars[0]), 32'd1);
         chk("shl_v1", 32'(vals[1]), 32'b01100);
         chk("shl_c1", 32'(cars[1]), 32'd0);
         chk("shl_v2", 32'(vals[2]), 32'b11000);
         chk("shl_c2", 32'(cars[2]), 32'd0);
         chk("shl_gap1", 32'(cyc[1] - cyc[0]), 32'd4);
         chk("shl_gap2", 32'(cyc[2] - cyc[1]), 32'd4);
         chk("shl_done_at", 32'(dcyc), 32'(cyc[2]));
      end
      chk("shl_done_cnt", 32'(dcnt), 32'd1);

      // Inputs ignored in WAIT; command presented in the done cycle runs on the next tick
      n = 0;
      while (!cmd_ready && n < 40) begin @(negedge clk); n++; end
      cmd_op = 3'b001; cmd_data = 5'b00101; cmd_amt = '0; cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_data = 5'b11111;
      n = 0;
      while (!done && n < 40) begin @(negedge clk); n++; end
      chk("hs_first_done", 32'(done), 32'd1);
      chk("hs_wait_ignored", 32'(acc), 32'b00101);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("hs_accepted", 32'(cmd_ready), 32'd0);
      n = 1;
      while (!done && n < 40) begin @(negedge clk); n++; end
      chk("hs_next_tick_lat", 32'(n), 32'd4);
      chk("hs_second_acc", 32'(acc), 32'b11111);

      // SHR by 1 then by 0
      run(3'b101, 5'b00000, 3'd1);
      chk("shr1_acc",   32'(acc),   32'b01111);
      chk("shr1_carry", 32'(carry), 32'd1);
      send(3'b101, 5'b00000, 3'd0);
      wait_done(n);
      chk("shr0_lat",   32'(n >= 1 && n <= 4), 32'd1);
      chk("shr0_acc",   32'(acc),   32'b01111);
      chk("shr0_carry", 32'(carry), 32'd1);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);

      // Shift amounts at and past WIDTH
      run(3'b001, 5'b10011, 3'd0);
      run(3'b101, 5'b00000, 3'd5);
      chk("shr5_acc",   32'(acc),   32'd0);
      chk("shr5_carry", 32'(carry), 32'd1);
      run(3'b001, 5'b10011, 3'd0);
      run(3'b101, 5'b00000, 3'd6);
      chk("shr6_acc",   32'(acc),   32'd0);
      chk("shr6_carry", 32'(carry), 32'd0);
      run(3'b001, 5'b10011, 3'd0);
      run(3'b100, 5'b00000, 3'd5);
      chk("shl5_acc",   32'(acc),   32'd0);
      chk("shl5_carry", 32'(carry), 32'd1);

      // Reset in the middle of SHL by 3
      run(3'b001, 5'b10011, 3'd0);
      send(3'b100, 5'b00000, 3'd3);
      n = 0;
      while (acc !== 5'b00110 && n < 20) begin @(negedge clk); n++; end
      chk("mid_shl_step", 32'(acc), 32'b00110);
      reset = 1'b1;
      dseen = 0;
      @(negedge clk);
      chk("mid_rst_acc",   32'(acc),       32'd0);
      chk("mid_rst_carry", 32'(carry),     32'd0);
      chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
      chk("mid_rst_tick",  32'(tick),      32'd0);
      if (done) dseen++;
      @(negedge clk);
      if (done) dseen++;
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) dseen++;
      end
      chk("mid_rst_nodone", 32'(dseen), 32'd0);
      chk("mid_rst_acc_hold", 32'(acc), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
      $fatal(1, "timeout");
   end

endmodule
